// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU control path: opcode values,
// ALU function codes, accumulator source codes, FSM stage encoding and the
// decoded-instruction record used by the control unit.
package cpu_pkg;

  localparam int OPCODE_MIN_WIDTH = 5;

  localparam logic [4:0] OPC_HLT  = 5'h00;
  localparam logic [4:0] OPC_STO  = 5'h01;
  localparam logic [4:0] OPC_LD   = 5'h02;
  localparam logic [4:0] OPC_LDI  = 5'h03;
  localparam logic [4:0] OPC_ADD  = 5'h04;
  localparam logic [4:0] OPC_ADDI = 5'h05;
  localparam logic [4:0] OPC_SUB  = 5'h06;
  localparam logic [4:0] OPC_SUBI = 5'h07;
  localparam logic [4:0] OPC_BEQ  = 5'h08;
  localparam logic [4:0] OPC_BNE  = 5'h09;
  localparam logic [4:0] OPC_BGT  = 5'h0A;
  localparam logic [4:0] OPC_BGE  = 5'h0B;
  localparam logic [4:0] OPC_BLT  = 5'h0C;
  localparam logic [4:0] OPC_BLE  = 5'h0D;
  localparam logic [4:0] OPC_JMP  = 5'h0E;
  localparam logic [4:0] OPC_AND  = 5'h0F;
  localparam logic [4:0] OPC_ANDI = 5'h10;
  localparam logic [4:0] OPC_OR   = 5'h11;
  localparam logic [4:0] OPC_ORI  = 5'h12;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_AND = 2'd2;
  localparam logic [1:0] ALU_OR  = 2'd3;

  localparam logic [1:0] SEL_A_MEM = 2'b00;
  localparam logic [1:0] SEL_A_IMM = 2'b01;
  localparam logic [1:0] SEL_A_ALU = 2'b10;

  typedef enum logic [2:0] {
    ST_RESET    = 3'd0,
    ST_FETCH    = 3'd1,
    ST_DEC      = 3'd2,
    ST_EXEC     = 3'd3,
    ST_HALT     = 3'd4,
    ST_MEM_WAIT = 3'd5
  } stage_t;

  typedef struct packed {
    logic       isHlt;
    logic       isSto;
    logic       accWr;
    logic       statusWr;
    logic [1:0] selA;
    logic       selB;
    logic [1:0] aluOp;
  } decode_t;

endpackage

// File: rtl/control_unit_branch_eval.sv
// Branch condition evaluator: decides whether the current opcode redirects
// the PC, given the status flags left by the previous ALU instruction.
module branch_eval
  import cpu_pkg::*;
#(
  parameter int OPCODE_WIDTH = 5
) (
  input  logic [OPCODE_WIDTH-1:0] opcode_i,
  input  logic                    flag_z_i,
  input  logic                    flag_n_i,
  output logic                    taken_o
);

  // Map each branch opcode onto its flag condition; everything else falls through
  always_comb begin
    taken_o = 1'b0;
    case (opcode_i)
      OPCODE_WIDTH'(OPC_BEQ): taken_o = flag_z_i;
      OPCODE_WIDTH'(OPC_BNE): taken_o = !flag_z_i;
      OPCODE_WIDTH'(OPC_BGT): taken_o = !flag_z_i && !flag_n_i;
      OPCODE_WIDTH'(OPC_BGE): taken_o = !flag_n_i;
      OPCODE_WIDTH'(OPC_BLT): taken_o = flag_n_i;
      OPCODE_WIDTH'(OPC_BLE): taken_o = flag_n_i || flag_z_i;
      OPCODE_WIDTH'(OPC_JMP): taken_o = 1'b1;
      default:                taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Control unit of the accumulator CPU: a FETCH/DEC/EXEC sequencer that turns
// the current opcode into datapath selects and one-cycle write strobes.
// Optional feature macro CONTROL_UNIT_MEM_WAIT_EN adds a mem_ready input and a
// MEM_WAIT stage that stalls LD/STO until data memory signals completion.
module control_unit
  import cpu_pkg::*;
#(
  parameter int OPCODE_WIDTH = 5,
  parameter int ALU_OP_WIDTH = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [OPCODE_WIDTH-1:0] op_code,
  input  logic                    flag_z,
  input  logic                    flag_n,
`ifdef CONTROL_UNIT_MEM_WAIT_EN
  input  logic                    mem_ready,
`endif
  output logic                    branch,
  output logic [1:0]              sel_a,
  output logic                    sel_b,
  output logic [ALU_OP_WIDTH-1:0] op,
  output logic                    pc_wr,
  output logic                    acc_wr,
  output logic                    status_wr,
  output logic                    data_memory_wr,
  output logic                    acc_reset,
  output logic                    pc_reset,
  output logic                    status_reset,
  output logic                    halted,
  output logic [2:0]              stage
);

  stage_t  state_q, state_d;
  decode_t dec;
  logic    taken;
  logic    decodeActive;

  branch_eval #(.OPCODE_WIDTH(OPCODE_WIDTH)) u_branch_eval (
    .opcode_i (op_code),
    .flag_z_i (flag_z),
    .flag_n_i (flag_n),
    .taken_o  (taken)
  );

`ifdef CONTROL_UNIT_MEM_WAIT_EN
  logic memOp;
  assign memOp = dec.isSto || (op_code == OPCODE_WIDTH'(OPC_LD));
`endif

  // Selects are only meaningful while an instruction is in flight
  assign decodeActive = (state_q == ST_DEC) || (state_q == ST_EXEC) ||
                        (state_q == ST_MEM_WAIT);

  // Translate the opcode into selects and which registers it commits
  always_comb begin
    dec = '0;
    case (op_code)
      OPCODE_WIDTH'(OPC_HLT):  dec.isHlt = 1'b1;
      OPCODE_WIDTH'(OPC_STO):  dec.isSto = 1'b1;
      OPCODE_WIDTH'(OPC_LD):   begin dec.accWr = 1'b1; dec.selA = SEL_A_MEM; end
      OPCODE_WIDTH'(OPC_LDI):  begin dec.accWr = 1'b1; dec.selA = SEL_A_IMM; end
      OPCODE_WIDTH'(OPC_ADD):  begin dec.accWr = 1'b1; dec.statusWr = 1'b1; dec.selA = SEL_A_ALU; dec.aluOp = ALU_ADD; end
      OPCODE_WIDTH'(OPC_ADDI): begin dec.accWr = 1'b1; dec.statusWr = 1'b1; dec.selA = SEL_A_ALU; dec.aluOp = ALU_ADD; dec.selB = 1'b1; end
      OPCODE_WIDTH'(OPC_SUB):  begin dec.accWr = 1'b1; dec.statusWr = 1'b1; dec.selA = SEL_A_ALU; dec.aluOp = ALU_SUB; end
      OPCODE_WIDTH'(OPC_SUBI): begin dec.accWr = 1'b1; dec.statusWr = 1'b1; dec.selA = SEL_A_ALU; dec.aluOp = ALU_SUB; dec.selB = 1'b1; end
      OPCODE_WIDTH'(OPC_AND):  begin dec.accWr = 1'b1; dec.statusWr = 1'b1; dec.selA = SEL_A_ALU; dec.aluOp = ALU_AND; end
      OPCODE_WIDTH'(OPC_ANDI): begin dec.accWr = 1'b1; dec.statusWr = 1'b1; dec.selA = SEL_A_ALU; dec.aluOp = ALU_AND; dec.selB = 1'b1; end
      OPCODE_WIDTH'(OPC_OR):   begin dec.accWr = 1'b1; dec.statusWr = 1'b1; dec.selA = SEL_A_ALU; dec.aluOp = ALU_OR; end
      OPCODE_WIDTH'(OPC_ORI):  begin dec.accWr = 1'b1; dec.statusWr = 1'b1; dec.selA = SEL_A_ALU; dec.aluOp = ALU_OR; dec.selB = 1'b1; end
      default:                 dec = '0;
    endcase
  end

  // State register; reset low drops straight back to RESET from any stage
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_RESET;
    else        state_q <= state_d;
  end

  // Sequence FETCH -> DEC -> EXEC, parking in HALT and optionally MEM_WAIT
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET: state_d = ST_FETCH;
      ST_FETCH: state_d = ST_DEC;
      ST_DEC:   state_d = ST_EXEC;
      ST_EXEC: begin
        if (dec.isHlt) state_d = ST_HALT;
`ifdef CONTROL_UNIT_MEM_WAIT_EN
        else if (memOp && !mem_ready) state_d = ST_MEM_WAIT;
`endif
        else state_d = ST_FETCH;
      end
      ST_HALT:  state_d = ST_HALT;
`ifdef CONTROL_UNIT_MEM_WAIT_EN
      ST_MEM_WAIT: state_d = mem_ready ? ST_FETCH : ST_MEM_WAIT;
`endif
      default:  state_d = ST_RESET;
    endcase
  end

  // Drive datapath selects, commit strobes and status from the current stage
  always_comb begin
    branch         = 1'b0;
    sel_a          = 2'b00;
    sel_b          = 1'b0;
    op             = '0;
    pc_wr          = 1'b0;
    acc_wr         = 1'b0;
    status_wr      = 1'b0;
    data_memory_wr = 1'b0;
    acc_reset      = 1'b0;
    pc_reset       = 1'b0;
    status_reset   = 1'b0;
    halted         = 1'b0;
    stage          = state_q;
    if (decodeActive) begin
      branch = taken;
      sel_a  = dec.selA;
      sel_b  = dec.selB;
      op     = ALU_OP_WIDTH'(dec.aluOp);
    end
    case (state_q)
      ST_RESET: begin
        acc_reset    = 1'b1;
        pc_reset     = 1'b1;
        status_reset = 1'b1;
      end
      ST_EXEC: begin
        pc_wr          = !dec.isHlt;
        acc_wr         = dec.accWr;
        status_wr      = dec.statusWr;
        data_memory_wr = dec.isSto;
`ifdef CONTROL_UNIT_MEM_WAIT_EN
        if (memOp && !mem_ready) begin
          pc_wr  = 1'b0;
          acc_wr = 1'b0;
        end
`endif
      end
      ST_HALT: halted = 1'b1;
`ifdef CONTROL_UNIT_MEM_WAIT_EN
      ST_MEM_WAIT: begin
        data_memory_wr = dec.isSto;
        if (mem_ready) begin
          pc_wr  = 1'b1;
          acc_wr = dec.accWr;
        end
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed instruction sequences plus
// randomized opcodes/flags, checked against a behavioural instruction model.
// Build with CONTROL_UNIT_MEM_WAIT_EN defined to also exercise memory stalls.
module tb_control_unit;

  logic       clock;
  logic       reset;
  logic [4:0] opCode;
  logic       flagZ;
  logic       flagN;
`ifdef CONTROL_UNIT_MEM_WAIT_EN
  logic       memReady;
`endif
  logic       branch;
  logic [1:0] selA;
  logic       selB;
  logic [1:0] aluOp;
  logic       pcWr, accWr, statusWr, dataMemoryWr;
  logic       accReset, pcReset, statusReset, halted;
  logic [2:0] stage;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic       br;
    logic [1:0] selA;
    logic       selB;
    logic [1:0] op;
    logic       pc;
    logic       acc;
    logic       st;
    logic       dmw;
  } exp_t;

  control_unit #(.OPCODE_WIDTH(5), .ALU_OP_WIDTH(2)) dut (
    .clock          (clock),
    .reset          (reset),
    .op_code        (opCode),
    .flag_z         (flagZ),
    .flag_n         (flagN),
`ifdef CONTROL_UNIT_MEM_WAIT_EN
    .mem_ready      (memReady),
`endif
    .branch         (branch),
    .sel_a          (selA),
    .sel_b          (selB),
    .op             (aluOp),
    .pc_wr          (pcWr),
    .acc_wr         (accWr),
    .status_wr      (statusWr),
    .data_memory_wr (dataMemoryWr),
    .acc_reset      (accReset),
    .pc_reset       (pcReset),
    .status_reset   (statusReset),
    .halted         (halted),
    .stage          (stage)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Instruction-level behaviour: what each opcode selects and commits in EXEC
  function automatic exp_t refModel(int opc, bit z, bit n);
    exp_t e;
    bit   isAlu;
    e = '0;
    isAlu = (opc >= 4 && opc <= 7) || (opc >= 15 && opc <= 18);
    case (opc)
      8:  e.br = z;
      9:  e.br = !z;
      10: e.br = !z && !n;
      11: e.br = !n;
      12: e.br = n;
      13: e.br = n || z;
      14: e.br = 1'b1;
      default: e.br = 1'b0;
    endcase
    if (isAlu) begin
      e.selA = 2'b10;
      e.acc  = 1'b1;
      e.st   = 1'b1;
      e.selB = (opc == 5 || opc == 7 || opc == 16 || opc == 18);
      if (opc < 8) e.op = 2'((opc - 4) / 2);
      else         e.op = (opc <= 16) ? 2'd2 : 2'd3;
    end
    if (opc == 2) e.acc = 1'b1;
    if (opc == 3) begin e.acc = 1'b1; e.selA = 2'b01; end
    if (opc == 1) e.dmw = 1'b1;
    e.pc = (opc != 0);
    return e;
  endfunction

  task automatic checkOutput(string tag, logic [31:0] observed, logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(int opc, bit z, bit n);
    opCode = 5'(opc);
    flagZ  = z;
    flagN  = n;
  endtask

  // Compare every output against the model for the given stage
  task automatic checkState(string tag, int expStage, exp_t e, bit decodeOn, bit strobesOn);
    checkOutput({tag, ".stage"},     32'(stage),        32'(expStage));
    checkOutput({tag, ".branch"},    32'(branch),       decodeOn  ? 32'(e.br)   : 32'd0);
    checkOutput({tag, ".sel_a"},     32'(selA),         decodeOn  ? 32'(e.selA) : 32'd0);
    checkOutput({tag, ".sel_b"},     32'(selB),         decodeOn  ? 32'(e.selB) : 32'd0);
    checkOutput({tag, ".op"},        32'(aluOp),        decodeOn  ? 32'(e.op)   : 32'd0);
    checkOutput({tag, ".pc_wr"},     32'(pcWr),         strobesOn ? 32'(e.pc)   : 32'd0);
    checkOutput({tag, ".acc_wr"},    32'(accWr),        strobesOn ? 32'(e.acc)  : 32'd0);
    checkOutput({tag, ".status_wr"}, 32'(statusWr),     strobesOn ? 32'(e.st)   : 32'd0);
    checkOutput({tag, ".dmem_wr"},   32'(dataMemoryWr), strobesOn ? 32'(e.dmw)  : 32'd0);
    checkOutput({tag, ".resets"},    32'({accReset, pcReset, statusReset}),
                (expStage == 0) ? 32'h7 : 32'h0);
    checkOutput({tag, ".halted"},    32'(halted),       32'(expStage == 4));
  endtask

  // Run one instruction starting just after the negedge of a FETCH cycle
  task automatic runInstruction(string tag, int opc, bit z, bit n);
    exp_t e;
    e = refModel(opc, z, n);
    applyStimulus(opc, z, n);
    #1 checkState({tag, ".fetch"}, 1, e, 1'b0, 1'b0);
    @(negedge clock); #1 checkState({tag, ".dec"}, 2, e, 1'b1, 1'b0);
    @(negedge clock); #1 checkState({tag, ".exec"}, 3, e, 1'b1, 1'b1);
    @(negedge clock); #1 checkState({tag, ".next"}, (opc == 0) ? 4 : 1, e, 1'b0, 1'b0);
  endtask

  initial begin
    exp_t e0;
    e0 = '0;
    reset = 1'b1;
    applyStimulus(0, 1'b0, 1'b0);
`ifdef CONTROL_UNIT_MEM_WAIT_EN
    memReady = 1'b1;
`endif
    #2 reset = 1'b0;
    @(negedge clock); #1 checkState("reset", 0, e0, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clock); #1 checkState("release", 1, e0, 1'b0, 1'b0);

    runInstruction("ldi",      3, 1'b0, 1'b0);
    runInstruction("addi",     5, 1'b0, 1'b0);
    runInstruction("bgt_z0n0", 10, 1'b0, 1'b0);
    runInstruction("bgt_z0n1", 10, 1'b0, 1'b1);
    runInstruction("ble_n1",   13, 1'b0, 1'b1);
    runInstruction("jmp",      14, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    runInstruction("undef1f",  31, 1'b1, 1'b1);
    runInstruction("sto",      1, 1'b0, 1'b0);
    runInstruction("ld",       2, 1'b0, 1'b0);

    // Reset asserted in the middle of an ADD's EXEC cycle
    begin
      exp_t eAdd;
      eAdd = refModel(4, 1'b0, 1'b0);
      applyStimulus(4, 1'b0, 1'b0);
      #1 checkState("rstmid.fetch", 1, eAdd, 1'b0, 1'b0);
      @(negedge clock); #1 checkState("rstmid.dec", 2, eAdd, 1'b1, 1'b0);
      @(negedge clock); #1 checkState("rstmid.exec", 3, eAdd, 1'b1, 1'b1);
      reset = 1'b0;
      #1 checkState("rstmid.reset", 0, eAdd, 1'b0, 1'b0);
      @(negedge clock); reset = 1'b1;
      #1 checkState("rstmid.held", 0, eAdd, 1'b0, 1'b0);
      @(negedge clock); #1 checkState("rstmid.fetch2", 1, eAdd, 1'b0, 1'b0);
    end

    for (int i = 0; i < 150; i++) begin
      int opc;
      opc = int'($urandom_range(1, 31));
      runInstruction($sformatf("rnd%0d_op%0h", i, opc), opc,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

`ifdef CONTROL_UNIT_MEM_WAIT_EN
    // STO stalled three cycles on mem_ready
    applyStimulus(1, 1'b0, 1'b0);
    memReady = 1'b0;
    @(negedge clock); #1 checkOutput("mw.dec", 32'(stage), 32'd2);
    @(negedge clock); #1;
    checkOutput("mw.exec.stage", 32'(stage), 32'd3);
    checkOutput("mw.exec.pc_wr", 32'(pcWr), 32'd0);
    checkOutput("mw.exec.dmem",  32'(dataMemoryWr), 32'd1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clock); #1;
      checkOutput("mw.wait.stage", 32'(stage), 32'd5);
      checkOutput("mw.wait.pc_wr", 32'(pcWr), 32'd0);
      checkOutput("mw.wait.dmem",  32'(dataMemoryWr), 32'd1);
    end
    @(negedge clock); memReady = 1'b1; #1;
    checkOutput("mw.ready.stage", 32'(stage), 32'd5);
    checkOutput("mw.ready.pc_wr", 32'(pcWr), 32'd1);
    checkOutput("mw.ready.dmem",  32'(dataMemoryWr), 32'd1);
    @(negedge clock); #1;
    checkOutput("mw.after.stage", 32'(stage), 32'd1);
    checkOutput("mw.after.pc_wr", 32'(pcWr), 32'd0);
`endif

    runInstruction("ldi2",  3, 1'b0, 1'b0);
    runInstruction("addi2", 5, 1'b1, 1'b0);
    runInstruction("hlt",   0, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      applyStimulus(int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      @(negedge clock); #1 checkState($sformatf("halt%0d", k), 4, e0, 1'b0, 1'b0);
    end
    reset = 1'b0;
    #1 checkState("halt.reset", 0, e0, 1'b0, 1'b0);
    @(negedge clock); reset = 1'b1;
    @(negedge clock); #1 checkState("halt.refetch", 1, e0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have parameter OPCODE_WIDTH, default 5, instruction opcode field width (min 5).
REQ-002 SHALL have parameter ALU_OP_WIDTH, default 2, ALU operation select width (min 2).
REQ-003 SHALL have ports: clock in 1 system clock; reset in 1 asynchronous, active-low reset.
REQ-004 SHALL have ports: op_code in OPCODE_WIDTH current instruction opcode; flag_z in 1 status zero flag; flag_n in 1 status negative flag.
REQ-005 SHALL have port mem_ready in 1 data memory access done (present only with CONTROL_UNIT_MEM_WAIT_EN).
REQ-006 SHALL have outputs: branch 1 PC source select; sel_a 2 accumulator source (00 mem, 01 imm, 10 ALU); sel_b 1 ALU operand B (0 mem, 1 imm); op ALU_OP_WIDTH ALU function (0 add, 1 sub, 2 and, 3 or).
REQ-007 SHALL have outputs: pc_wr, acc_wr, status_wr, data_memory_wr 1 each, register write strobes; acc_reset, pc_reset, status_reset 1 each, synchronous clears to datapath; halted 1 core stopped; stage 3 current FSM state code.

Function
REQ-008 SHALL implement FSM states RESET=0, FETCH=1, DEC=2, EXEC=3, HALT=4, MEM_WAIT=5, encoded on stage.
REQ-009 SHALL transition RESET->FETCH->DEC->EXEC each clock; EXEC->FETCH except as REQ-010/REQ-021.
REQ-010 SHALL transition EXEC->HALT on HLT (0x00); HALT SHALL persist until reset, halted=1 only in HALT.
REQ-011 SHALL decode opcodes: HLT 00, STO 01, LD 02, LDI 03, ADD 04, ADDI 05, SUB 06, SUBI 07, BEQ 08, BNE 09, BGT 0A, BGE 0B, BLT 0C, BLE 0D, JMP 0E, AND 0F, ANDI 10, OR 11, ORI 12.
REQ-012 SHALL treat any undefined opcode as NOP: pc_wr=1 in EXEC, all other strobes 0.
REQ-013 SHALL drive sel_a/sel_b/op/branch from op_code in both DEC and EXEC (stable through commit); 0 in RESET, FETCH, HALT.
REQ-014 SHALL compute branch taken as: BEQ z; BNE !z; BGT !z&&!n; BGE !n; BLT n; BLE n||z; JMP 1; non-branch 0.
REQ-015 SHALL assert write strobes only in EXEC (or MEM_WAIT), each for exactly one cycle per instruction, except data_memory_wr per REQ-021.
REQ-016 SHALL in EXEC assert: STO pc_wr,data_memory_wr; LD/LDI pc_wr,acc_wr; ALU ops pc_wr,acc_wr,status_wr; branches/JMP pc_wr only; HLT none.
REQ-017 SHALL assert acc_reset, pc_reset, status_reset only in RESET state.
REQ-018 SHALL sample flag_z/flag_n combinationally in EXEC (flags from preceding instruction's status_wr).

Reset
REQ-019 SHALL on reset low immediately force state RESET regardless of current state (including mid-MEM_WAIT or HALT); outputs: *_reset=1, all others 0, stage=0.
REQ-020 SHALL leave RESET on the first rising clock after reset deasserts, reaching FETCH.

Configuration
REQ-021 SHALL, with CONTROL_UNIT_MEM_WAIT_EN defined, for LD/STO in EXEC with mem_ready=0 suppress pc_wr/acc_wr, go to MEM_WAIT, hold data_memory_wr=1 (STO) through MEM_WAIT, and commit pc_wr (+acc_wr for LD) in the cycle mem_ready=1, then FETCH.
REQ-022 SHALL, without CONTROL_UNIT_MEM_WAIT_EN, omit mem_ready and MEM_WAIT; LD/STO complete in EXEC unconditionally.

Structure
REQ-023 SHALL place opcode constants, stage enum type and ALU op constants in shared package cpu_pkg.
REQ-024 SHALL contain one sub-module branch_eval (opcode, flags -> taken), combinational.

Verification
REQ-025 Reset low mid-EXEC of ADD -> stage=0, acc/pc/status_reset=1 same cycle, no strobes; release -> FETCH next edge.
REQ-026 LDI then ADDI then HLT -> EXEC strobes per REQ-016, sel_a 01/10, sel_b 1, then stage=4, halted=1 for 20 cycles.
REQ-027 BGT with z=0,n=0 -> branch=1; z=0,n=1 -> branch=0; BLE with n=1 -> branch=1; JMP -> branch=1 any flags.
REQ-028 Opcode 0x1F -> EXEC pc_wr=1 only, returns to FETCH.
REQ-029 MEM_WAIT_EN: STO, mem_ready low 3 cycles -> data_memory_wr=1 4 cycles, pc_wr single pulse on ready, then FETCH.
